layer_mac_sched: RTL and testbench

Time-multiplexed scheduler for one fully-connected ANN layer in the ECG classifier. It reuses a single signed 16×16 multiply-accumulate unit across all `N_IN` inputs and `N_OUT` neurons of the layer, instead of instantiating one parallel node per neuron. Per neuron it fetches weights and bias from an external synchronous weight ROM, accumulates at full precision, rescales, saturates and optionally rectifies the result. It sits between the previous layer's output stream and the next layer's input buffer.

---
 rtl/layer_mac_sched_pkg.sv | 30 +++
 rtl/layer_mac_sched_if.sv | 34 +++
 rtl/layer_mac_sched_mac.sv | 60 ++++++
 rtl/layer_mac_sched.sv | 157 +++++++++++++++
 tb/tb_layer_mac_sched.sv | 210 +++++++++++++++++++++
 5 files changed

// File: rtl/layer_mac_sched_pkg.sv
// ann_pkg: shared Q8.8 constants, saturation helper and scheduler state type.
// Used by layer_mac_sched and mac_unit; build option LAYER_RELU_EN lives in mac_unit.
package ann_pkg;

  localparam int W_DEF    = 16;
  localparam int FRAC_DEF = 8;
  localparam int ONE_Q    = 1 << FRAC_DEF;

  localparam logic signed [63:0] Q_MAX = (64'sd1 <<< (W_DEF - 1)) - 64'sd1;
  localparam logic signed [63:0] Q_MIN = -(64'sd1 <<< (W_DEF - 1));

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    RUN   = 2'd1,
    DRAIN = 2'd2,
    EMIT  = 2'd3
  } state_t;

  // Clamp a wide signed value into the W_DEF-bit signed range.
  function automatic logic signed [W_DEF-1:0] sat_q(input logic signed [63:0] v);
    if (v > Q_MAX) begin
      sat_q = Q_MAX[W_DEF-1:0];
    end else if (v < Q_MIN) begin
      sat_q = Q_MIN[W_DEF-1:0];
    end else begin
      sat_q = v[W_DEF-1:0];
    end
  endfunction

endpackage

// File: rtl/layer_mac_sched_if.sv
// Bus bundle for layer_mac_sched: input buffer writes, control, weight ROM port, result stream.
// master = layer environment (producer, ROM, consumer); slave = the scheduler.
interface layer_mac_sched_if #(
  parameter int N_IN  = 30,
  parameter int N_OUT = 8,
  parameter int W     = 16
);
  localparam int IA = $clog2(N_IN);
  localparam int JW = $clog2(N_OUT);
  localparam int WA = $clog2(N_OUT * (N_IN + 1));

  logic                in_wr;
  logic [IA-1:0]       in_addr;
  logic signed [W-1:0] in_data;
  logic                start;
  logic                busy;
  logic                done;
  logic [WA-1:0]       w_addr;
  logic signed [W-1:0] w_data;
  logic                out_valid;
  logic [JW-1:0]       out_idx;
  logic signed [W-1:0] out_data;

  modport master (
    output in_wr, in_addr, in_data, start, w_data,
    input  busy, done, w_addr, out_valid, out_idx, out_data
  );

  modport slave (
    input  in_wr, in_addr, in_data, start, w_data,
    output busy, done, w_addr, out_valid, out_idx, out_data
  );

endinterface

// File: rtl/layer_mac_sched_mac.sv
// mac_unit: registered signed multiply, full-precision accumulate, shift/saturate (+ReLU if LAYER_RELU_EN).
// Latency: product 1 cycle after operands, accumulate 1 cycle later; res reflects the accumulator's next value.
// No backpressure: the scheduler paces operands and clears between neurons.
module mac_unit
  import ann_pkg::*;
#(
  parameter int W     = W_DEF,
  parameter int FRAC  = FRAC_DEF,
  parameter int ACC_W = 40
) (
  input  logic                clk,
  input  logic                reset,
  input  logic                clr,
  input  logic                mul_en,
  input  logic signed [W-1:0] x,
  input  logic signed [W-1:0] w,
  output logic signed [W-1:0] res
);

  logic signed [2*W-1:0]   prod;
  logic                    acc_en;
  logic signed [ACC_W-1:0] acc;
  logic signed [ACC_W-1:0] acc_nxt;
  logic signed [ACC_W-1:0] acc_shr;
  logic signed [W-1:0]     sat;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      prod   <= '0;
      acc_en <= 1'b0;
      acc    <= '0;
    end else begin
      acc_en <= mul_en;
      if (mul_en) begin
        prod <= x * w;
      end
      acc <= acc_nxt;
    end
  end

  always_comb begin
    acc_nxt = acc;
    if (clr) begin
      acc_nxt = '0;
    end else if (acc_en) begin
      acc_nxt = acc + ACC_W'(prod);
    end
  end

  // Result is taken from the next accumulator value so the scheduler can register it on the final add.
  assign acc_shr = acc_nxt >>> FRAC;
  assign sat     = W'(sat_q(64'(acc_shr)));

`ifdef LAYER_RELU_EN
  assign res = sat[W-1] ? '0 : sat;
`else
  assign res = sat;
`endif

endmodule

// File: rtl/layer_mac_sched.sv
// layer_mac_sched: one FC layer on a single time-shared MAC; optional ReLU via LAYER_RELU_EN.
// Latency: N_IN+4 cycles per neuron, start to done N_OUT*(N_IN+4); weight ROM read latency 1.
// No backpressure: each out_valid pulse must be taken; start/in_wr while busy are dropped.
module layer_mac_sched
  import ann_pkg::*;
#(
  parameter int N_IN  = 30,
  parameter int N_OUT = 8,
  parameter int W     = W_DEF,
  parameter int FRAC  = FRAC_DEF,
  parameter int ACC_W = 40
) (
  input logic              clk,
  input logic              reset,
  layer_mac_sched_if.slave bus
);

  localparam int IA = $clog2(N_IN);
  localparam int KW = $clog2(N_IN + 1);
  localparam int JW = $clog2(N_OUT);
  localparam int WA = $clog2(N_OUT * (N_IN + 1));

  localparam logic [IA-1:0]       IN_LAST = IA'(N_IN - 1);
  localparam logic [KW-1:0]       K_BIAS  = KW'(N_IN);
  localparam logic [JW-1:0]       J_LAST  = JW'(N_OUT - 1);
  localparam logic signed [W-1:0] X_ONE   = W'(ONE_Q);

  state_t state;
  state_t state_nxt;

  logic [KW-1:0]       k;
  logic [JW-1:0]       j;
  logic                dcnt;
  logic [WA-1:0]       w_addr_q;
  logic signed [W-1:0] xbuf [N_IN];
  logic signed [W-1:0] x_d;
  logic                mul_en;
  logic                clr;
  logic signed [W-1:0] res;

  logic                out_valid_q;
  logic                done_q;
  logic [JW-1:0]       out_idx_q;
  logic signed [W-1:0] out_data_q;

  logic launch;
  logic last_k;
  logic last_j;
  logic cap;

  assign launch = (state == IDLE) && bus.start;
  assign last_k = (k == K_BIAS);
  assign last_j = (j == J_LAST);
  assign cap    = (state == DRAIN) && dcnt;
  assign clr    = launch || (state == EMIT);

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state <= IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (bus.start) state_nxt = RUN;
      RUN:     if (last_k)    state_nxt = DRAIN;
      DRAIN:   if (dcnt)      state_nxt = EMIT;
      EMIT:    state_nxt = last_j ? IDLE : RUN;
      default: state_nxt = IDLE;
    endcase
  end

  // w_addr only ever advances: within a neuron for k < N_IN, and from the bias word to the next row on EMIT.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      k        <= '0;
      j        <= '0;
      dcnt     <= 1'b0;
      w_addr_q <= '0;
      x_d      <= '0;
      mul_en   <= 1'b0;
    end else begin
      mul_en <= (state == RUN);
      dcnt   <= (state == DRAIN) ? ~dcnt : 1'b0;
      if (state == RUN) begin
        x_d <= last_k ? X_ONE : xbuf[k[IA-1:0]];
      end
      if (launch) begin
        k        <= '0;
        j        <= '0;
        w_addr_q <= '0;
      end else if (state == RUN) begin
        if (!last_k) begin
          k        <= k + 1'b1;
          w_addr_q <= w_addr_q + 1'b1;
        end
      end else if (state == EMIT) begin
        k <= '0;
        if (!last_j) begin
          j        <= j + 1'b1;
          w_addr_q <= w_addr_q + 1'b1;
        end
      end
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      for (int i = 0; i < N_IN; i++) begin
        xbuf[i] <= '0;
      end
    end else if (bus.in_wr && (state == IDLE) && (bus.in_addr <= IN_LAST)) begin
      xbuf[bus.in_addr] <= bus.in_data;
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      out_valid_q <= 1'b0;
      done_q      <= 1'b0;
      out_idx_q   <= '0;
      out_data_q  <= '0;
    end else begin
      out_valid_q <= cap;
      done_q      <= cap && last_j;
      if (cap) begin
        out_idx_q  <= j;
        out_data_q <= res;
      end
    end
  end

  mac_unit #(
    .W     (W),
    .FRAC  (FRAC),
    .ACC_W (ACC_W)
  ) u_mac (
    .clk    (clk),
    .reset  (reset),
    .clr    (clr),
    .mul_en (mul_en),
    .x      (x_d),
    .w      (bus.w_data),
    .res    (res)
  );

  assign bus.busy      = (state != IDLE);
  assign bus.done      = done_q;
  assign bus.w_addr    = w_addr_q;
  assign bus.out_valid = out_valid_q;
  assign bus.out_idx   = out_idx_q;
  assign bus.out_data  = out_data_q;

endmodule

// File: tb/tb_layer_mac_sched.sv
// Scoreboard bench for layer_mac_sched: a behavioural ROM, a reference model per neuron,
// expectations queued at start and retired on each out_valid.
module tb_layer_mac_sched;
  import ann_pkg::*;

  localparam int N_IN  = 30;
  localparam int N_OUT = 8;
  localparam int W     = 16;
  localparam int PER   = N_IN + 4;
  localparam int ROWS  = N_IN + 1;

  logic clk = 1'b0;
  logic reset = 1'b0;
  always #5 clk = ~clk;

  layer_mac_sched_if #(.N_IN(N_IN), .N_OUT(N_OUT), .W(W)) bus ();

  layer_mac_sched #(
    .N_IN  (N_IN),
    .N_OUT (N_OUT),
    .W     (W),
    .FRAC  (8),
    .ACC_W (40)
  ) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  logic signed [15:0] rom [256];
  int xs [N_IN];
  int exp_idx_q [$];
  int exp_dat_q [$];
  int n_chk = 0;
  int n_pass = 0;
  int mon_i;
  int mon_d;

  always @(posedge clk) bus.w_data <= rom[bus.w_addr];

  task automatic check(input string tag, input longint got, input longint exp);
    n_chk++;
    if (got == exp) n_pass++;
    else $display("FAIL %s: got %0d expected %0d", tag, got, exp);
  endtask

  always @(negedge clk) begin
    if (reset && bus.out_valid) begin
      if (exp_idx_q.size() == 0) begin
        check("sb_unexpected_out", 1, 0);
      end else begin
        mon_i = exp_idx_q.pop_front();
        mon_d = exp_dat_q.pop_front();
        check("out_idx", bus.out_idx, mon_i);
        check("out_data", bus.out_data, mon_d);
      end
    end
  end

  function automatic int model(input int j);
    longint s;
    longint r;
    s = 0;
    for (int k = 0; k < N_IN; k++) s += longint'(xs[k]) * longint'(rom[j*ROWS+k]);
    s += longint'(ONE_Q) * longint'(rom[j*ROWS+N_IN]);
    r = s >>> 8;
    if (r > 32767) r = 32767;
    else if (r < -32768) r = -32768;
`ifdef LAYER_RELU_EN
    if (r < 0) r = 0;
`endif
    return int'(r);
  endfunction

  task automatic set_rom(input int wt, input int bias_base, input int bias_step);
    for (int a = 0; a < 256; a++) rom[a] = '0;
    for (int j = 0; j < N_OUT; j++) begin
      for (int k = 0; k < N_IN; k++) rom[j*ROWS+k] = 16'(wt);
      rom[j*ROWS+N_IN] = 16'(bias_base + j*bias_step);
    end
  endtask

  task automatic wr_x(input int addr, input int v);
    @(posedge clk); #1;
    bus.in_wr   = 1'b1;
    bus.in_addr = 5'(addr);
    bus.in_data = 16'(v);
    @(posedge clk); #1;
    bus.in_wr = 1'b0;
    if (addr < N_IN) xs[addr] = v;
  endtask

  task automatic load_x(input int v);
    for (int k = 0; k < N_IN; k++) wr_x(k, v);
    wr_x(31, 12345);  // out-of-range address must not land anywhere
  endtask

  task automatic check_all_zero(input string tag);
    check({tag, "_busy"}, bus.busy, 0);
    check({tag, "_done"}, bus.done, 0);
    check({tag, "_out_valid"}, bus.out_valid, 0);
    check({tag, "_out_idx"}, bus.out_idx, 0);
    check({tag, "_out_data"}, bus.out_data, 0);
    check({tag, "_w_addr"}, bus.w_addr, 0);
  endtask

  task automatic run_layer(input bit coin_wr, input int inj_at, input int abort_at, input bit chk_addr);
    int n;
    int c;
    int p;
    bit got_done;
    if (coin_wr) xs[0] = 256;
    for (int j = 0; j < N_OUT; j++) begin
      exp_idx_q.push_back(j);
      exp_dat_q.push_back(model(j));
    end
    @(posedge clk); #1;
    bus.start = 1'b1;
    if (coin_wr) begin
      bus.in_wr   = 1'b1;
      bus.in_addr = 5'd0;
      bus.in_data = 16'sd256;
    end
    n = 0;
    got_done = 1'b0;
    while (!got_done && n < 400) begin
      @(posedge clk); #1;
      n++;
      bus.start = 1'b0;
      bus.in_wr = 1'b0;
      if (n == 1) check("busy_rise", bus.busy, 1);
      if (n == inj_at) begin
        bus.start   = 1'b1;
        bus.in_wr   = 1'b1;
        bus.in_addr = 5'd3;
        bus.in_data = -16'sd1000;
      end
      if (chk_addr) begin
        c = n - 1;
        p = c % PER;
        if (p <= N_IN) check("w_addr", bus.w_addr, (c / PER) * ROWS + p);
      end
      if (n == abort_at) begin
        reset = 1'b0;
        #1;
        check_all_zero("midreset");
        exp_idx_q.delete();
        exp_dat_q.delete();
        return;
      end
      if (bus.done) got_done = 1'b1;
    end
    check("done_cycle", n, N_OUT * PER);
    @(posedge clk); #1;
    check("done_pulse_len", bus.done, 0);
    check("busy_fall", bus.busy, 0);
    check("sb_drained", exp_idx_q.size(), 0);
  endtask

  initial begin
    bus.in_wr   = 1'b0;
    bus.in_addr = '0;
    bus.in_data = '0;
    bus.start   = 1'b0;
    for (int k = 0; k < N_IN; k++) xs[k] = 0;
    set_rom(0, 0, 0);
    reset = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    check_all_zero("reset");
    reset = 1'b1;
    @(posedge clk); #1;

    // Unity sum: 30 * 1.0 * 1.0 = 30.0 -> 7680
    load_x(256);
    set_rom(256, 0, 0);
    run_layer(1'b0, 0, 0, 1'b0);

    // Sign handling, with x0 rewritten in the same cycle as start
    wr_x(0, 0);
    set_rom(-256, -128, 0);
    run_layer(1'b1, 0, 0, 1'b0);

    // Saturation both directions
    load_x(32767);
    set_rom(32767, 0, 0);
    run_layer(1'b0, 0, 0, 1'b0);
    set_rom(-32768, 0, 0);
    run_layer(1'b0, 0, 0, 1'b0);

    // start / in_wr during evaluation are dropped
    load_x(256);
    set_rom(256, 0, 0);
    run_layer(1'b0, 100, 0, 1'b0);

    // Reset mid-layer clears the buffer; next run yields bias only
    set_rom(256, 0, 256);
    run_layer(1'b0, 0, 50, 1'b0);
    repeat (2) @(posedge clk);
    #1;
    reset = 1'b1;
    for (int k = 0; k < N_IN; k++) xs[k] = 0;
    @(posedge clk); #1;
    run_layer(1'b0, 0, 0, 1'b1);

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
